// File: rtl/sccb_reg_responder.sv
// SCCB/I2C target with a 16-bit auto-incrementing register pointer and a byte-wide register bank.
// Pin-to-event latency is 3 clk (2 sync + edge detect); the target never stretches SCL, so no backpressure.
module sccb_reg_responder #(
   parameter logic [6:0]           DEV_ADDR = 7'h36,
   parameter logic [15:0]          REG_BASE = 16'h0000,
   parameter int                   REG_NUM  = 8,
   parameter logic [8*REG_NUM-1:0] REG_RST  = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 scl_in,
   input  logic                 sda_in,
   output logic                 sda_oe,
   output logic [8*REG_NUM-1:0] reg_bank,
   output logic                 wr_strobe,
   output logic [15:0]          wr_addr,
   output logic [7:0]           wr_data,
   output logic                 busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_DEVA, S_ACK_DEV, S_ADDR_HI, S_ACK_HI, S_ADDR_LO,
      S_ACK_LO, S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_ACK, S_WAIT
   } state_t;

   state_t      state, state_nxt;
   logic        scl_s1, scl_s2, scl_d;
   logic        sda_s1, sda_s2, sda_d;
   logic        scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]  sh;
   logic [7:0]  byte_in;
   logic [7:0]  rd_byte;
   logic [2:0]  bit_cnt;
   logic        byte_full;
   logic        rw;
   logic [15:0] ptr;
   logic [15:0] idx;
   logic        in_range;
   logic        sda_oe_nxt, busy_nxt;
   logic        sample, cnt_inc, cnt_clr, full_set, full_clr;
   logic        ld_hi, ld_lo, commit, ptr_inc, rd_load, rd_shift, rw_ld;

   // Synchronizers reset to the idle-bus level so release of reset cannot fake an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         {scl_s1, scl_s2, scl_d} <= 3'b111;
         {sda_s1, sda_s2, sda_d} <= 3'b111;
      end else begin
         {scl_s1, scl_s2, scl_d} <= {scl_in, scl_s1, scl_s2};
         {sda_s1, sda_s2, sda_d} <= {sda_in, sda_s1, sda_s2};
      end
   end

   assign scl_rise  = scl_s2 & ~scl_d;
   assign scl_fall  = ~scl_s2 & scl_d;
   assign start_det = scl_s2 & scl_d & ~sda_s2 & sda_d;
   assign stop_det  = scl_s2 & scl_d & sda_s2 & ~sda_d;

   assign byte_in  = {sh[6:0], sda_s2};
   assign idx      = ptr - REG_BASE;
   assign in_range = (idx < 16'(REG_NUM));

   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < REG_NUM; i++) begin
         if (in_range && (idx == 16'(i))) rd_byte = reg_bank[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         sda_oe <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         sda_oe <= sda_oe_nxt;
         busy   <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      sda_oe_nxt = sda_oe;
      busy_nxt   = busy;
      sample     = 1'b0;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;
      full_set   = 1'b0;
      full_clr   = 1'b0;
      ld_hi      = 1'b0;
      ld_lo      = 1'b0;
      commit     = 1'b0;
      ptr_inc    = 1'b0;
      rd_load    = 1'b0;
      rd_shift   = 1'b0;
      rw_ld      = 1'b0;
      if (start_det) begin
         state_nxt  = S_DEVA;
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b1;
         cnt_clr    = 1'b1;
         full_clr   = 1'b1;
      end else if (stop_det) begin
         state_nxt  = S_IDLE;
         sda_oe_nxt = 1'b0;
         busy_nxt   = 1'b0;
         cnt_clr    = 1'b1;
         full_clr   = 1'b1;
      end else begin
         case (state)
            S_DEVA, S_ADDR_HI, S_ADDR_LO, S_WR_DATA: begin
               if (scl_rise && !byte_full) begin
                  sample = 1'b1;
                  if (bit_cnt == 3'd7) begin
                     full_set = 1'b1;
                     case (state)
                        S_DEVA:    rw_ld = 1'b1;
                        S_ADDR_HI: ld_hi = 1'b1;
                        S_ADDR_LO: ld_lo = 1'b1;
                        default: begin
                           commit  = in_range;
                           ptr_inc = 1'b1;
                        end
                     endcase
                  end
               end else if (scl_fall && byte_full) begin
                  // Byte boundary: either take the ACK slot or drop off the bus.
                  full_clr = 1'b1;
                  cnt_clr  = 1'b1;
                  if ((state == S_DEVA) && (sh[7:1] != DEV_ADDR)) begin
                     state_nxt = S_WAIT;
                  end else begin
                     sda_oe_nxt = 1'b1;
                     case (state)
                        S_DEVA:    state_nxt = S_ACK_DEV;
                        S_ADDR_HI: state_nxt = S_ACK_HI;
                        S_ADDR_LO: state_nxt = S_ACK_LO;
                        default:   state_nxt = S_ACK_WR;
                     endcase
                  end
               end
            end
            S_ACK_DEV: begin
               if (scl_fall) begin
                  cnt_clr = 1'b1;
                  if (rw) begin
                     state_nxt  = S_RD_DATA;
                     rd_load    = 1'b1;
                     sda_oe_nxt = ~rd_byte[7];
                  end else begin
                     state_nxt  = S_ADDR_HI;
                     sda_oe_nxt = 1'b0;
                  end
               end
            end
            S_ACK_HI: begin
               if (scl_fall) begin
                  state_nxt  = S_ADDR_LO;
                  sda_oe_nxt = 1'b0;
               end
            end
            S_ACK_LO, S_ACK_WR: begin
               if (scl_fall) begin
                  state_nxt  = S_WR_DATA;
                  sda_oe_nxt = 1'b0;
               end
            end
            S_RD_DATA: begin
               if (scl_rise && !byte_full) begin
                  cnt_inc = 1'b1;
                  if (bit_cnt == 3'd7) full_set = 1'b1;
               end else if (scl_fall) begin
                  if (byte_full) begin
                     full_clr   = 1'b1;
                     sda_oe_nxt = 1'b0;
                     state_nxt  = S_RD_ACK;
                  end else begin
                     rd_shift   = 1'b1;
                     sda_oe_nxt = ~sh[6];
                  end
               end
            end
            S_RD_ACK: begin
               // byte_full marks a received master ACK until the slot's falling edge.
               if (scl_rise && !byte_full) begin
                  if (sda_s2) begin
                     state_nxt = S_WAIT;
                  end else begin
                     ptr_inc  = 1'b1;
                     full_set = 1'b1;
                  end
               end else if (scl_fall && byte_full) begin
                  full_clr   = 1'b1;
                  cnt_clr    = 1'b1;
                  rd_load    = 1'b1;
                  sda_oe_nxt = ~rd_byte[7];
                  state_nxt  = S_RD_DATA;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh        <= 8'h00;
         bit_cnt   <= 3'd0;
         byte_full <= 1'b0;
         rw        <= 1'b0;
         ptr       <= 16'h0000;
         wr_strobe <= 1'b0;
         wr_addr   <= 16'h0000;
         wr_data   <= 8'h00;
         reg_bank  <= REG_RST;
      end else begin
         if (sample)        sh <= byte_in;
         else if (rd_load)  sh <= rd_byte;
         else if (rd_shift) sh <= {sh[6:0], 1'b0};

         if (cnt_clr)                bit_cnt <= 3'd0;
         else if (sample || cnt_inc) bit_cnt <= bit_cnt + 3'd1;

         if (full_clr)      byte_full <= 1'b0;
         else if (full_set) byte_full <= 1'b1;

         if (rw_ld) rw <= sda_s2;

         if (ld_hi)        ptr[15:8] <= byte_in;
         else if (ld_lo)   ptr[7:0]  <= byte_in;
         else if (ptr_inc) ptr       <= ptr + 16'd1;

         wr_strobe <= commit;
         if (commit) begin
            wr_addr <= ptr;
            wr_data <= byte_in;
            for (int i = 0; i < REG_NUM; i++) begin
               if (idx == 16'(i)) reg_bank[8*i +: 8] <= byte_in;
            end
         end
      end
   end

endmodule

// File: doc/sccb_reg_responder.md
# sccb_reg_responder

SCCB/I2C target (responder) with 16-bit register addressing and an internal byte-wide register bank. It is the other end of the two-byte-address write/read transactions the camera-init IIC master issues. It lets an external host or that master configure figure-detection controls, such as threshold and display mode, over the same two-wire bus. It also serves as the bus model for verifying the IIC master. It sits on `clk_100MHz_system` beside the IIC driver, with SDA handled by an external IOBUF.

## Interface
Parameters:
- DEV_ADDR, 7'h36, 7-bit target address; write byte 0x6C, read byte 0x6D.
- REG_BASE, 16'h0000, register address of bank entry 0.
- REG_NUM, 8, number of bank bytes (1..16).
- REG_RST, 64'h0, flat reset image; byte i resets to REG_RST[8i+7:8i].

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- scl_in  in  1  bus SCL; asynchronous to clk.
- sda_in  in  1  bus SDA from IOBUF O; asynchronous to clk.
- sda_oe  out  1  1 = pull SDA low (drives IOBUF T inverted, I tied 0).
- reg_bank  out  8*REG_NUM  flat register contents; byte i at [8i+7:8i].
- wr_strobe  out  1  one-cycle pulse when a bank byte is written.
- wr_addr  out  16  register address of the last write; valid with wr_strobe.
- wr_data  out  8  data of the last write; valid with wr_strobe.
- busy  out  1  high from START to STOP.

## Operation
- scl_in and sda_in each pass through a 2-flop synchronizer and one edge-detect register.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Bits are sampled on detected SCL rising edges, MSB first. sda_oe changes only on detected SCL falling edges.
- States:
  - IDLE: wait for START.
  - DEVA: shift 8 bits. If bits[7:1] == DEV_ADDR, go to ACK_DEV; otherwise go to WAIT.
  - ACK_DEV: drive ACK for one SCL low/high period. R/W=0 goes to ADDR_HI; R/W=1 goes to RD_DATA.
  - ADDR_HI and ACK_HI: load ptr[15:8].
  - ADDR_LO and ACK_LO: load ptr[7:0].
  - WR_DATA and ACK_WR: write one byte, then ptr += 1 (16-bit wrap, 0xFFFF → 0x0000). Repeat until STOP or Sr.
  - RD_DATA: drive the byte at ptr.
  - RD_ACK: sample master ACK/NACK. ACK sets ptr += 1 and returns to RD_DATA. NACK goes to WAIT.
  - WAIT: sda_oe = 0; ignore bits until START or STOP.
- START, including repeated start in any state, goes to DEVA. STOP in any state goes to IDLE and releases sda_oe. ptr is retained across STOP and Sr, so the SCCB form "write address, STOP, START, read" works.
- Bank index = ptr − REG_BASE, valid when 0 ≤ index < REG_NUM.
  - Out-of-range write: still ACKed; the bank does not change and there is no wr_strobe.
  - Out-of-range read: returns 0x00.
- Read drive: for each data bit, sda_oe = ~bit. sda_oe is released during the master ACK slot.
- Reset values: sda_oe = 0, busy = 0, wr_strobe = 0, wr_addr = 0, wr_data = 0, ptr = 0, state = IDLE, reg_bank = REG_RST.

## Timing
- Input latency is 3 clk from a pin edge to the internal event (2 sync + 1 edge). The bus requires SCL high and low phases of at least 10 clk each (≤ 400 kHz is comfortably met).
- ACK: sda_oe rises 1 clk after the detected SCL fall that ends bit 8. It falls 1 clk after the next detected SCL fall.
- Write commit: on the detected SCL rise of data bit 8, in the following clk:
  - reg_bank is updated;
  - wr_strobe = 1 for exactly 1 clk;
  - wr_addr = ptr and wr_data = byte.
  - ptr increments in the same cycle.
- Read: the byte is latched from the bank at the detected SCL fall that ends the ACK. The MSB drives 1 clk later, and each later bit 1 clk after its SCL fall.
- busy rises 1 clk after a detected START and falls 1 clk after a detected STOP.
- START and STOP take priority over bit sampling in the same cycle.
- rst_n asserted mid-transaction: sda_oe = 0 immediately (asynchronously), and the block returns to IDLE. The remainder of that transaction is ignored until the next START.

## Test plan
- Reset check: with REG_RST=64'h0807060504030201, reset gives reg_bank == that value, sda_oe = 0, and busy = 0.
- Single write: S 0x6C 0x00 0x02 0xA5 P gives 4 ACKs and bank byte 2 = 0xA5. wr_strobe fires once with wr_addr = 0x0002 and wr_data = 0xA5, and busy covers S..P.
- Burst write: S 0x6C 0x00 0x06 0x11 0x22 0x33 P gives byte6 = 0x11 and byte7 = 0x22. The third byte goes to 0x0008, which is out of range: it is ACKed, with no strobe and no change.
- Read: S 0x6C 0x00 0x02 Sr 0x6D, then master ACK and NACK.
  - Data returned is 0xA5 then byte3.
  - sda_oe is released during both master ACK slots.
  - After NACK, sda_oe stays 0 until P.
- Address mismatch: S 0x70 0x00 0x02 0xFF P gives no ACK on any byte, no strobe, and an unchanged bank.
- Reset mid-transaction: assert rst_n low during the data-byte ACK. sda_oe drops within the same cycle, and the next full write transaction succeeds.
